// File: rtl/tdm_demultiplexer.sv
// Receive end of a 4-slot TDM link: tracks slot alignment from frame_sync,
// gathers one sample per slot and publishes all four lanes once per frame.
module tdm_demultiplexer #(
  parameter int LANE_WIDTH = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANE_WIDTH-1:0] serial_in,
  input  logic                  bit_en,
  input  logic                  frame_sync,
  output logic [LANE_WIDTH-1:0] out0,
  output logic [LANE_WIDTH-1:0] out1,
  output logic [LANE_WIDTH-1:0] out2,
  output logic [LANE_WIDTH-1:0] out3,
  output logic                  addr0,
  output logic                  addr1,
  output logic                  locked,
  output logic                  frame_valid,
  output logic                  sync_err
);

  // Last flywheel miss still tolerated; one more miss drops lock.
  localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t                state;
  logic [1:0]            slot;
  logic [2:0]            miss_cnt;
  logic [LANE_WIDTH-1:0] shadow0, shadow1, shadow2;

  assign {addr1, addr0} = slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= 2'd0;
      miss_cnt    <= 3'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      locked      <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (bit_en) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              shadow0  <= serial_in;
              slot     <= 2'd1;
              miss_cnt <= 3'd0;
              state    <= LOCKED;
              locked   <= 1'b1;
            end
          end
          LOCKED: begin
            if (frame_sync) begin
              // A marker anywhere but slot 0 is a slip: restart the frame here.
              shadow0  <= serial_in;
              slot     <= 2'd1;
              miss_cnt <= 3'd0;
              if (slot != 2'd0) sync_err <= 1'b1;
            end else begin
              case (slot)
                2'd0: begin
                  if (miss_cnt < MISS_LAST) begin
                    miss_cnt <= miss_cnt + 3'd1;
                    shadow0  <= serial_in;
                    slot     <= 2'd1;
                  end else begin
                    state    <= HUNT;
                    locked   <= 1'b0;
                    slot     <= 2'd0;
                    miss_cnt <= 3'd0;
                    sync_err <= 1'b1;
                  end
                end
                2'd1: begin
                  shadow1 <= serial_in;
                  slot    <= 2'd2;
                end
                2'd2: begin
                  shadow2 <= serial_in;
                  slot    <= 2'd3;
                end
                default: begin
                  out0        <= shadow0;
                  out1        <= shadow1;
                  out2        <= shadow2;
                  out3        <= serial_in;
                  frame_valid <= 1'b1;
                  slot        <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
            slot   <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demultiplexer.sv
// Scoreboard bench for tdm_demultiplexer: a frame-level reference model pushes
// expected frame/error events; a negedge monitor pops and compares them.
module tb_tdm_demultiplexer;
  localparam int W  = 1;
  localparam int ML = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] serial_in = '0;
  logic         bit_en = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] out0, out1, out2, out3;
  logic         addr0, addr1, locked, frame_valid, sync_err;

  tdm_demultiplexer #(.LANE_WIDTH(W), .MISS_LIMIT(ML)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_en(bit_en),
    .frame_sync(frame_sync), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .addr0(addr0), .addr1(addr1), .locked(locked), .frame_valid(frame_valid),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               is_frame;
    logic [3:0][W-1:0]  lanes;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  errors  = 0;
  bit  chk_on  = 0;

  // Reference model: position within frame, lock flag, miss run, collected samples.
  bit                m_locked;
  int                m_pos;
  int                m_miss;
  logic [3:0][W-1:0] m_frame;
  logic [3:0][W-1:0] m_lanes;

  function automatic void model(input logic rst, input logic be, input logic fs,
                                input logic [W-1:0] d);
    ev_t e;
    if (rst) begin
      m_locked = 0; m_pos = 0; m_miss = 0; m_frame = '0; m_lanes = '0;
      return;
    end
    if (!be) return;
    if (!m_locked) begin
      if (fs) begin
        m_frame[0] = d; m_pos = 1; m_miss = 0; m_locked = 1;
      end
    end else if (fs) begin
      if (m_pos != 0) begin
        e.is_frame = 0; e.lanes = '0; q.push_back(e);
      end
      m_frame[0] = d; m_pos = 1; m_miss = 0;
    end else if (m_pos == 0) begin
      m_miss++;
      if (m_miss >= ML) begin
        m_locked = 0; m_miss = 0;
        e.is_frame = 0; e.lanes = '0; q.push_back(e);
      end else begin
        m_frame[0] = d; m_pos = 1;
      end
    end else begin
      m_frame[m_pos] = d;
      if (m_pos == 3) begin
        m_lanes = m_frame;
        e.is_frame = 1; e.lanes = m_lanes; q.push_back(e);
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      logic [1:0] pos2;
      ev_t e;
      pos2 = 2'(m_pos);
      check("addr", 32'({addr1, addr0}), 32'(pos2));
      check("locked", 32'(locked), 32'(m_locked));
      check("lanes", 32'({out3, out2, out1, out0}), 32'(m_lanes));
      if (frame_valid && sync_err) check("pulse_exclusive", 32'd1, 32'd0);
      if (frame_valid || sync_err) begin
        if (q.size() == 0) begin
          check("spurious_pulse", 32'({frame_valid, sync_err}), 32'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", 32'({frame_valid, sync_err}), 32'({e.is_frame, !e.is_frame}));
          if (e.is_frame) check("frame_lanes", 32'({out3, out2, out1, out0}), 32'(e.lanes));
        end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        check("missing_pulse", 32'({frame_valid, sync_err}), 32'({e.is_frame, !e.is_frame}));
      end
    end
  end

  task automatic step(input logic rst, input logic be, input logic fs, input logic [W-1:0] d);
    @(negedge clk);
    reset = rst; bit_en = be; frame_sync = fs; serial_in = d;
    @(posedge clk);
    #1;
    model(rst, be, fs, d);
  endtask

  // b[i] is the slot-i sample, fsm[i] drives frame_sync on slot i.
  task automatic send_frame(input logic [3:0] b, input bit gaps, input logic [3:0] fsm);
    for (int i = 0; i < 4; i++) begin
      if (gaps) step(0, 0, 0, '0);
      step(0, 1, fsm[i], W'(b[i]));
    end
  endtask

  initial begin
    step(1, 0, 0, '0);
    chk_on = 1;
    step(1, 0, 0, '0);

    send_frame(4'b1101, 0, 4'b0001);        // slots 1,0,1,1
    send_frame(4'b1101, 0, 4'b0001);
    send_frame(4'b0010, 1, 4'b0001);        // slots 0,1,0,0 with gaps
    send_frame(4'b1111, 0, 4'b0101);        // slip on slot 2
    step(0, 1, 0, 1'b0);
    step(0, 1, 0, 1'b1);
    send_frame(4'b0110, 0, 4'b0001);
    send_frame(4'b1001, 0, 4'b0000);        // single miss: flywheel
    send_frame(4'b0101, 0, 4'b0000);        // second miss: lock lost
    for (int i = 0; i < 4; i++) step(0, 1, 0, W'(i & 1));
    send_frame(4'b1010, 0, 4'b0001);
    step(0, 1, 1, 1'b1);
    step(0, 1, 0, 1'b1);
    step(1, 0, 0, '0);                      // reset after slot 1
    send_frame(4'b0111, 0, 4'b0001);

    for (int n = 0; n < 3000; n++) begin
      logic be, fs, rst;
      rst = ($urandom % 300) == 0;
      be  = ($urandom % 4) != 0;
      if (m_pos == 0) fs = ($urandom % 8) != 0;
      else            fs = ($urandom % 20) == 0;
      step(rst, be, fs, W'($urandom));
    end
    step(0, 0, 0, '0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
